// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default sizes for the parametrised register file
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

endpackage

// File: rtl/regfile_init_sweep.sv
// rtl/regfile_init_sweep.sv - post-reset sweep FSM that zeroes every entry once, then reports ready
module regfile_init_sweep
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic              o_init_we,
  output logic [ADDR_W-1:0] o_init_addr,
  output logic              o_ready
);

  localparam logic [ADDR_W-1:0] LP_LAST = {ADDR_W{1'b1}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= INIT;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // The clear of the last entry and the move to RUN share one edge.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    o_init_we   = 1'b0;
    case (r_state)
      INIT: begin
        o_init_we = ~i_reset;
        w_ptr_nxt = r_ptr + 1'b1;
        if (r_ptr == LP_LAST) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = INIT;
      end
    endcase
  end

  assign o_init_addr = r_ptr;
  assign o_ready     = (r_state == RUN);

endmodule

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - DEPTH x DATA_W register file, one write and two registered read ports with bypass
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              ReadEn1,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic              ReadEn2,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              ReadValid1,
  output logic              ReadValid2,
  output logic              Ready
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam bit LP_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_init_we;
  logic [ADDR_W-1:0] w_init_addr;
  logic              w_ready;
  logic              w_user_we;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rval1;
  logic [DATA_W-1:0] w_rval2;
  logic [DATA_W-1:0] r_rdata1;
  logic [DATA_W-1:0] r_rdata2;
  logic              r_rvalid1;
  logic              r_rvalid2;

  regfile_init_sweep #(
    .ADDR_W (ADDR_W)
  ) u_init_sweep (
    .i_clk       (Clk),
    .i_reset     (Reset),
    .o_init_we   (w_init_we),
    .o_init_addr (w_init_addr),
    .o_ready     (w_ready)
  );

  // Writes to the hardwired zero entry are dropped so the bypass never sees them either.
  assign w_user_we = w_ready && RegWrite && !(LP_ZERO && (WriteReg == '0));
  assign w_we      = w_init_we || w_user_we;
  assign w_waddr   = w_init_we ? w_init_addr : WriteReg;
  assign w_wdata   = w_init_we ? '0 : WriteData;

  // No reset on the array itself so it can be mapped onto a RAM.
  always_ff @(posedge Clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_comb begin
    w_rval1 = '0;
    if (!(LP_ZERO && (ReadReg1 == '0))) begin
      if (w_user_we && (WriteReg == ReadReg1)) begin
        w_rval1 = WriteData;
      end else begin
        w_rval1 = r_mem[ReadReg1];
      end
    end
  end

  always_comb begin
    w_rval2 = '0;
    if (!(LP_ZERO && (ReadReg2 == '0))) begin
      if (w_user_we && (WriteReg == ReadReg2)) begin
        w_rval2 = WriteData;
      end else begin
        w_rval2 = r_mem[ReadReg2];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rdata1  <= '0;
      r_rdata2  <= '0;
      r_rvalid1 <= 1'b0;
      r_rvalid2 <= 1'b0;
    end else if (w_ready) begin
      r_rvalid1 <= ReadEn1;
      r_rvalid2 <= ReadEn2;
      if (ReadEn1) begin
        r_rdata1 <= w_rval1;
      end
      if (ReadEn2) begin
        r_rdata2 <= w_rval2;
      end
    end else begin
      r_rvalid1 <= 1'b0;
      r_rvalid2 <= 1'b0;
    end
  end

  assign ReadData1  = r_rdata1;
  assign ReadData2  = r_rdata2;
  assign ReadValid1 = r_rvalid1;
  assign ReadValid2 = r_rvalid2;
  assign Ready      = w_ready;

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - directed-vector bench for regfile_param, zero-reg and ordinary-reg0 instances
module tb_regfile_param;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        ReadEn1;
  logic [4:0]  ReadReg1;
  logic        ReadEn2;
  logic [4:0]  ReadReg2;

  logic [31:0] z_rd1, z_rd2, n_rd1, n_rd2;
  logic        z_rv1, z_rv2, n_rv1, n_rv2;
  logic        z_ready, n_ready;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 Clk = ~Clk;

  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_dut (
    .Clk(Clk), .Reset(Reset), .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .ReadEn1(ReadEn1), .ReadReg1(ReadReg1), .ReadEn2(ReadEn2), .ReadReg2(ReadReg2),
    .ReadData1(z_rd1), .ReadData2(z_rd2), .ReadValid1(z_rv1), .ReadValid2(z_rv2), .Ready(z_ready)
  );

  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_dut_nz (
    .Clk(Clk), .Reset(Reset), .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .ReadEn1(ReadEn1), .ReadReg1(ReadReg1), .ReadEn2(ReadEn2), .ReadReg2(ReadReg2),
    .ReadData1(n_rd1), .ReadData2(n_rd2), .ReadValid1(n_rv1), .ReadValid2(n_rv2), .Ready(n_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled at the following falling edge.
  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idle();
    RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    ReadEn1 = 1'b0; ReadReg1 = '0; ReadEn2 = 1'b0; ReadReg2 = '0;
  endtask

  task automatic sweep_and_check(input string tag);
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk({tag, "_ready"}, {31'b0, z_ready}, (i < 32) ? 32'd0 : 32'd1);
    end
    chk({tag, "_ready_nz"}, {31'b0, n_ready}, 32'd1);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    idle();
    RegWrite = 1'b1; WriteReg = a; WriteData = d;
    tick();
    idle();
  endtask

  initial begin
    idle();
    Reset = 1'b1;
    @(negedge Clk);
    tick();
    tick();
    chk("rst_rd1", z_rd1, 32'd0);
    chk("rst_rd2", z_rd2, 32'd0);
    chk("rst_rv1", {31'b0, z_rv1}, 32'd0);
    chk("rst_ready", {31'b0, z_ready}, 32'd0);

    // T1: sweep timing, then every entry reads zero on both ports.
    Reset = 1'b0;
    sweep_and_check("t1");
    for (int a = 0; a < 32; a++) begin
      ReadEn1 = 1'b1; ReadReg1 = 5'(a);
      ReadEn2 = 1'b1; ReadReg2 = 5'(31 - a);
      tick();
      chk("t1_rd1", z_rd1, 32'd0);
      chk("t1_rd2", z_rd2, 32'd0);
      chk("t1_rv1", {31'b0, z_rv1}, 32'd1);
      chk("t1_nz_rd1", n_rd1, 32'd0);
    end
    idle();

    // T2: write then read next cycle; ReadEn low holds data and drops valid.
    wr(5'd5, 32'hDEADBEEF);
    ReadEn1 = 1'b1; ReadReg1 = 5'd5;
    tick();
    chk("t2_rd1", z_rd1, 32'hDEADBEEF);
    chk("t2_rv1", {31'b0, z_rv1}, 32'd1);
    chk("t2_rv2", {31'b0, z_rv2}, 32'd0);
    idle();
    tick();
    chk("t2_hold_rd1", z_rd1, 32'hDEADBEEF);
    chk("t2_hold_rv1", {31'b0, z_rv1}, 32'd0);

    // T3: same-cycle bypass to both ports, and the write lands in the array.
    wr(5'd7, 32'h00000001);
    RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'h12345678;
    ReadEn1 = 1'b1; ReadReg1 = 5'd7; ReadEn2 = 1'b1; ReadReg2 = 5'd7;
    tick();
    chk("t3_byp_rd1", z_rd1, 32'h12345678);
    chk("t3_byp_rd2", z_rd2, 32'h12345678);
    chk("t3_byp_rv2", {31'b0, z_rv2}, 32'd1);
    idle();
    ReadEn2 = 1'b1; ReadReg2 = 5'd7;
    ReadEn1 = 1'b1; ReadReg1 = 5'd5;
    tick();
    chk("t3_later_rd2", z_rd2, 32'h12345678);
    chk("t3_other_rd1", z_rd1, 32'hDEADBEEF);

    // T4: register 0 hardwired in one instance, ordinary in the other.
    wr(5'd0, 32'hFFFFFFFF);
    ReadEn1 = 1'b1; ReadReg1 = 5'd0;
    tick();
    chk("t4_zero_rd1", z_rd1, 32'd0);
    chk("t4_nz_rd1", n_rd1, 32'hFFFFFFFF);
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h0BADF00D;
    ReadEn2 = 1'b1; ReadReg2 = 5'd0;
    tick();
    chk("t4_zero_byp_rd2", z_rd2, 32'd0);
    chk("t4_nz_byp_rd2", n_rd2, 32'h0BADF00D);
    idle();

    // T5: writes and reads during the sweep are ignored.
    Reset = 1'b1;
    tick();
    chk("t5_rst_ready", {31'b0, z_ready}, 32'd0);
    chk("t5_rst_rd1", z_rd1, 32'd0);
    Reset = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'h000000A5;
      ReadEn1 = 1'b1; ReadReg1 = 5'd3;
      tick();
      chk("t5_rv1", {31'b0, z_rv1}, 32'd0);
      chk("t5_rd1", z_rd1, 32'd0);
    end
    chk("t5_ready", {31'b0, z_ready}, 32'd1);
    idle();
    ReadEn1 = 1'b1; ReadReg1 = 5'd3;
    tick();
    chk("t5_r3_rd1", z_rd1, 32'd0);
    chk("t5_r3_rv1", {31'b0, z_rv1}, 32'd1);
    idle();

    // T6: reset pulse in RUN restarts the sweep and clears contents.
    for (int r = 1; r <= 4; r++) begin
      wr(5'(r), 32'(r));
    end
    ReadEn1 = 1'b1; ReadReg1 = 5'd4;
    ReadEn2 = 1'b1; ReadReg2 = 5'd2;
    tick();
    chk("t6_pre_rd1", z_rd1, 32'd4);
    chk("t6_pre_rd2", z_rd2, 32'd2);
    idle();
    Reset = 1'b1;
    tick();
    chk("t6_ready_drop", {31'b0, z_ready}, 32'd0);
    chk("t6_rst_rd1", z_rd1, 32'd0);
    Reset = 1'b0;
    sweep_and_check("t6");
    tick();
    chk("t6_idle_rd1", z_rd1, 32'd0);
    chk("t6_idle_rv1", {31'b0, z_rv1}, 32'd0);
    for (int r = 1; r <= 4; r++) begin
      ReadEn1 = 1'b1; ReadReg1 = 5'(r);
      ReadEn2 = 1'b1; ReadReg2 = 5'(r);
      tick();
      chk("t6_post_rd1", z_rd1, 32'd0);
      chk("t6_post_rd2", n_rd2, 32'd0);
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
